edgedet_multi: RTL and testbench

- Multi-channel, run-time configurable edge detector. Successor to the single-channel fixed-polarity detector.
- Per channel: optional input synchroniser, mode-selectable edge detection (rising/falling/both/off), a registered one-cycle pulse, a sticky event flag with clear, and a saturating event counter.
- Sits between raw GPIO/status inputs and the interrupt/CSR logic; the OR of the sticky flags forms an interrupt line.

---
 rtl/edgedet_multi.sv | 160 ++++++++++++++++
 tb/tb_edgedet_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/edgedet_multi.sv
// Multi-channel configurable edge detector: per-channel sync, edge detect, pulse, sticky flag, saturating counter.
// Optional per-channel debounce filter enabled with `define EDGEDET_DEBOUNCE_EN.

module edgedet_multi_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             din_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             pulse_o,
    output logic             flag_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic s;
    logic f;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = din_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= din_i;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef EDGEDET_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES + 1);
    logic [DBW-1:0] db_q;
    logic           f_q;

    // f follows s only after DB_CYCLES consecutive edges of disagreement; runs regardless of en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q <= '0;
            f_q  <= 1'b0;
        end else if (s != f_q) begin
            if (db_q == DBW'(DB_CYCLES - 1)) begin
                f_q  <= s;
                db_q <= '0;
            end else begin
                db_q <= db_q + DBW'(1);
            end
        end else begin
            db_q <= '0;
        end
    end
    assign f = f_q;
`else
    assign f = s;
`endif

    logic             prev_q;
    logic             pulse_q;
    logic             flag_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             det;
    logic             ev;

    always_comb begin
        det = 1'b0;
        unique case (mode_i)
            2'b00: det = 1'b0;
            2'b01: det = ~prev_q & f;
            2'b10: det = prev_q & ~f;
            2'b11: det = prev_q ^ f;
        endcase
    end

    assign ev = en_i & det;

    // Clear and event on the same edge leave the counter at one: the event is not lost.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = CNT_W'(ev);
        else if (ev && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (en_i) prev_q <= f;
            pulse_q <= ev;
            flag_q  <= ev | (flag_q & ~clr_i);
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;
    assign flag_o  = flag_q;
    assign cnt_o   = cnt_q;

endmodule

module edgedet_multi #(
    parameter  int NUM_CH      = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int CNT_W       = 8,
    parameter  int DB_CYCLES   = 4,
    localparam int SELW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_CH-1:0]     i,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     clr,
    input  logic [SELW-1:0]       cnt_sel,
    output logic [NUM_CH-1:0]     o,
    output logic [NUM_CH-1:0]     flag,
    output logic [CNT_W-1:0]      cnt,
    output logic                  irq
);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_all;

    edgedet_multi_lane #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .DB_CYCLES   (DB_CYCLES)
    ) u_lane [NUM_CH-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en),
        .din_i   (i),
        .mode_i  (mode),
        .clr_i   (clr),
        .pulse_o (o),
        .flag_o  (flag),
        .cnt_o   (cnt_all)
    );

    // Out-of-range selects read as zero rather than aliasing another channel.
    always_comb begin
        cnt = '0;
        if (32'(cnt_sel) < NUM_CH) cnt = cnt_all[cnt_sel];
    end

    assign irq = |flag;

endmodule

// File: tb/tb_edgedet_multi.sv
// Bench for edgedet_multi: directed vectors, literal checks, and a per-cycle behavioural model compare.
module tb_edgedet_multi;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 2;
    localparam int DB_CYCLES   = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef EDGEDET_DEBOUNCE_EN
    localparam int LAT = SYNC_STAGES + DB_CYCLES;
`else
    localparam int LAT = SYNC_STAGES;
`endif

    logic              clk = 1'b0;
    logic              rst_n, en;
    logic [NUM_CH-1:0] i, clr, o, flag;
    logic [7:0]        mode;
    logic [1:0]        cnt_sel;
    logic [CNT_W-1:0]  cnt;
    logic              irq;

    int vectors = 0;
    int miscompares = 0;
    int pc[NUM_CH];

    always #5 clk = ~clk;

    edgedet_multi #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i), .mode(mode), .clr(clr),
        .cnt_sel(cnt_sel), .o(o), .flag(flag), .cnt(cnt), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_count(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            for (int c = 0; c < NUM_CH; c++) if (o[c]) pc[c]++;
        end
        @(negedge clk);
    endtask

    task automatic clear_pc();
        for (int c = 0; c < NUM_CH; c++) pc[c] = 0;
    endtask

    // Model: s is i delayed SYNC_STAGES edges; debounced f flips once the last DB_CYCLES samples of s all disagree with it.
    logic [NUM_CH-1:0] ih [SYNC_STAGES];
    logic [NUM_CH-1:0] sh [DB_CYCLES];
    logic [NUM_CH-1:0] m_f, m_prev, m_o, m_flag;
    int                m_cnt[NUM_CH];

    initial begin : model
        logic [NUM_CH-1:0] s, fu;
        logic [1:0] md;
        bit started, r, fl, ev, all_diff;
        started = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                started = 1;
                for (int j = 0; j < SYNC_STAGES; j++) ih[j] = '0;
                for (int j = 0; j < DB_CYCLES; j++) sh[j] = '0;
                m_f = '0; m_prev = '0; m_o = '0; m_flag = '0;
                for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
            end else begin
                s = ih[SYNC_STAGES-1];
                for (int j = SYNC_STAGES - 1; j > 0; j--) ih[j] = ih[j-1];
                ih[0] = i;
`ifdef EDGEDET_DEBOUNCE_EN
                fu = m_f;
                for (int j = DB_CYCLES - 1; j > 0; j--) sh[j] = sh[j-1];
                sh[0] = s;
                for (int c = 0; c < NUM_CH; c++) begin
                    all_diff = 1;
                    for (int k = 0; k < DB_CYCLES; k++) if (sh[k][c] == m_f[c]) all_diff = 0;
                    if (all_diff) m_f[c] = s[c];
                end
`else
                fu = s;
`endif
                for (int c = 0; c < NUM_CH; c++) begin
                    md = mode[2*c +: 2];
                    r  = !m_prev[c] && fu[c];
                    fl = m_prev[c] && !fu[c];
                    ev = en && ((md[0] && r) || (md[1] && fl));
                    if (en) m_prev[c] = fu[c];
                    m_o[c] = ev;
                    if (clr[c]) m_cnt[c] = ev ? 1 : 0;
                    else if (ev && m_cnt[c] < CNT_MAX) m_cnt[c]++;
                    m_flag[c] = ev ? 1'b1 : (clr[c] ? 1'b0 : m_flag[c]);
                end
            end
            #1;
            if (started) begin
                chk("model_o", 32'(o), 32'(m_o));
                chk("model_flag", 32'(flag), 32'(m_flag));
                chk("model_irq", 32'(irq), 32'(|m_flag));
                chk("model_cnt", 32'(cnt), 32'(m_cnt[cnt_sel]));
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; en = 1'b0; i = '0; mode = '0; clr = '0; cnt_sel = '0;
        clear_pc();
        repeat (3) @(negedge clk);
        chk("reset_o", 32'(o), 0);
        chk("reset_flag", 32'(flag), 0);
        chk("reset_irq", 32'(irq), 0);
        chk("reset_cnt", 32'(cnt), 0);

        rst_n = 1'b1; en = 1'b1; mode = 8'h55;
        repeat (2) @(negedge clk);

        // rising latency on ch0
        i = 4'b0001;
        for (int e = 0; e <= LAT + 1; e++) begin
            @(posedge clk); #1;
            chk("rise_o", 32'(o), (e == LAT) ? 1 : 0);
        end
        chk("rise_flag", 32'(flag), 1);
        chk("rise_irq", 32'(irq), 1);
        chk("rise_cnt", 32'(cnt), 1);
        @(negedge clk);

        // modes: ch1 falling, ch2 both, ch3 off
        mode = 8'h39; cnt_sel = 2'd2; clr = 4'hF;
        @(negedge clk);
        clr = '0;
        chk("clr_all_flag", 32'(flag), 0);
        clear_pc();
        i = 4'b1111; run_count(LAT + 4);
        i = 4'b0001; run_count(LAT + 4);
        chk("mode_ch0_pulses", pc[0], 0);
        chk("mode_ch1_pulses", pc[1], 1);
        chk("mode_ch2_pulses", pc[2], 2);
        chk("mode_ch3_pulses", pc[3], 0);
        chk("mode_cnt2", 32'(cnt), 2);
        chk("mode_flag", 32'(flag), 4'b0110);

        // clear alone, then clear coincident with an event
        clr = 4'b0100; @(negedge clk); clr = '0;
        chk("clr2_flag", 32'(flag), 4'b0010);
        chk("clr2_cnt", 32'(cnt), 0);
        clr = 4'b0010; @(negedge clk); clr = '0;
        chk("clr1_irq", 32'(irq), 0);
        i = 4'b0101;
        repeat (LAT) @(negedge clk);
        clr = 4'b0100;
        @(posedge clk); #1;
        chk("clrev_o", 32'(o), 4'b0100);
        chk("clrev_flag", 32'(flag), 4'b0100);
        chk("clrev_cnt", 32'(cnt), 1);
        @(negedge clk);
        clr = '0;
        i = 4'b0001; run_count(LAT + 3);

        // saturation on ch0
        mode = 8'h55; cnt_sel = 2'd0; clr = 4'hF;
        @(negedge clk);
        clr = '0;
        chk("sat_start", 32'(cnt), 0);
        for (int r = 0; r < 5; r++) begin
            i = 4'b0000; run_count(LAT + 2);
            i = 4'b0001; run_count(LAT + 2);
            chk("sat_cnt", 32'(cnt), (r + 1 > 3) ? 3 : r + 1);
        end

        // enable gating
        i = 4'b0000; run_count(LAT + 2);
        clr = 4'hF; @(negedge clk); clr = '0;
        en = 1'b0; i = 4'b0001;
        clear_pc(); run_count(LAT + 6);
        chk("en_off_pulses", pc[0], 0);
        en = 1'b1;
        @(posedge clk); #1;
        chk("en_first_o", 32'(o), 4'b0001);
        clear_pc(); run_count(8);
        chk("en_after_pulses", pc[0], 0);
        chk("en_cnt", 32'(cnt), 1);

        // reset mid-operation drops the pending pulse
        i = 4'b0000; run_count(LAT + 2);
        i = 4'b0001;
        repeat (LAT) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_o", 32'(o), 0);
        chk("midrst_flag", 32'(flag), 0);
        chk("midrst_cnt", 32'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_pc(); run_count(LAT + 4);
        chk("post_rst_pulses", pc[0], 1);

`ifdef EDGEDET_DEBOUNCE_EN
        clear_pc();
        i = 4'b0011; run_count(3);
        i = 4'b0001; run_count(LAT + 6);
        chk("db_glitch_pulses", pc[1], 0);
        i = 4'b0011;
        for (int e = 0; e <= LAT + 1; e++) begin
            @(posedge clk); #1;
            chk("db_long_o", 32'(o), (e == LAT) ? 4'b0010 : 0);
        end
        @(negedge clk);
        i = 4'b0001; run_count(LAT + 4);
`else
        clear_pc();
        i = 4'b0011; @(negedge clk);
        i = 4'b0001; run_count(LAT + 4);
        chk("glitch_pulses", pc[1], 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
